// File: rtl/irtx_sequencer_if.sv
// irtx_sequencer_if
// Host-side bundle for the IR transmit sequencer: frame buffer write port,
// frame start/abort controls and the status/envelope outputs.
//   wr_en/wr_addr/wr_data : synchronous byte write into the frame buffer
//   len                   : frame length in bytes, latched when go is accepted
//   go / abort            : start request (level) / terminate frame in flight
//   busy / done / env     : frame active, completion pulse, mark/space envelope
interface irtx_sequencer_if #(
  parameter int AW = 5
);
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic [AW:0]   len;
  logic          go;
  logic          abort;
  logic          busy;
  logic          done;
  logic          env;

  modport master (
    output wr_en, wr_addr, wr_data, len, go, abort,
    input  busy, done, env
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, len, go, abort,
    output busy, done, env
  );
endinterface

// File: rtl/irtx_sequencer.sv
// irtx_sequencer
// Transmit-side envelope sequencer for the IR link. Plays a host-loaded frame
// of bytes as a pulse-distance envelope: header mark/space, one mark plus a
// bit-dependent space per data bit (LSB first, byte 0 first), then a tail mark.
// The carrier itself is applied downstream; env only gates it.
// Ports:
//   clk   : system clock (12 MHz)
//   reset : asynchronous, active-high reset (buffer contents survive it)
//   bus   : irtx_sequencer_if.slave - buffer writes, len/go/abort, busy/done/env
//
// state  | meaning
// IDLE   | waiting for go; buffer writable
// ZLEN   | zero-length frame accepted, one busy cycle
// HMARK  | header mark, env=1
// HSPACE | header space, env=0
// BMARK  | bit mark, env=1
// BSPACE | bit space, env=0, length set by the current bit
// TMARK  | tail mark, env=1
// FIN    | done pulse, back to IDLE
module irtx_sequencer #(
  parameter int DEPTH      = 32,
  parameter int AW         = 5,
  parameter int CW         = 16,
  parameter int HDR_MARK   = 42000,
  parameter int HDR_SPACE  = 20400,
  parameter int BIT_MARK   = 5280,
  parameter int ONE_SPACE  = 15600,
  parameter int ZERO_SPACE = 5280
) (
  input logic             clk,
  input logic             reset,
  irtx_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, ZLEN, HMARK, HSPACE, BMARK, BSPACE, TMARK, FIN
  } state_t;

  // Segment reload values: counter starts at length-1 and the segment ends on 0.
  localparam logic [CW-1:0] HM_L   = CW'(HDR_MARK - 1);
  localparam logic [CW-1:0] HS_L   = CW'(HDR_SPACE - 1);
  localparam logic [CW-1:0] BM_L   = CW'(BIT_MARK - 1);
  localparam logic [CW-1:0] OS_L   = CW'(ONE_SPACE - 1);
  localparam logic [CW-1:0] ZS_L   = CW'(ZERO_SPACE - 1);
  localparam logic [CW-1:0] CNT_1  = CW'(1);
  localparam logic [AW:0]   LEN_1  = (AW+1)'(1);
  localparam logic [AW:0]   LEN_MX = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] ADDR_0 = '0;
  localparam logic [AW-1:0] ADDR_1 = AW'(1);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [7:0]    sreg, sreg_n;
  logic [2:0]    bit_idx, bit_n;
  logic [AW:0]   byte_idx, byte_n;
  logic [AW:0]   len_q, len_n;
  logic          env_q, env_n;
  logic          busy_q, busy_n;
  logic          done_q, done_n;
  logic [AW-1:0] nxt_addr;
  logic          last_byte;
  logic [7:0]    mem [DEPTH];

  assign nxt_addr  = byte_idx[AW-1:0] + ADDR_1;
  assign last_byte = (byte_idx == (len_q - LEN_1));

  assign bus.env  = env_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

  // Buffer has no reset so a frame survives a reset of the sequencer.
  always_ff @(posedge clk) begin
    if (bus.wr_en && !busy_q)
      mem[bus.wr_addr] <= bus.wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      sreg     <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      len_q    <= '0;
      env_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      sreg     <= sreg_n;
      bit_idx  <= bit_n;
      byte_idx <= byte_n;
      len_q    <= len_n;
      env_q    <= env_n;
      busy_q   <= busy_n;
      done_q   <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sreg_n  = sreg;
    bit_n   = bit_idx;
    byte_n  = byte_idx;
    len_n   = len_q;

    case (state)
      IDLE: begin
        // abort in the same cycle as go suppresses the start
        if (bus.go && !bus.abort) begin
          len_n  = (bus.len > LEN_MX) ? LEN_MX : bus.len;
          byte_n = '0;
          bit_n  = '0;
          if (bus.len == '0) begin
            state_n = ZLEN;
          end else begin
            state_n = HMARK;
            cnt_n   = HM_L;
          end
        end
      end
      ZLEN: state_n = FIN;
      HMARK: begin
        if (cnt == '0) begin
          state_n = HSPACE;
          cnt_n   = HS_L;
        end else begin
          cnt_n = cnt - CNT_1;
        end
      end
      HSPACE: begin
        if (cnt == '0) begin
          state_n = BMARK;
          cnt_n   = BM_L;
          sreg_n  = mem[ADDR_0];
        end else begin
          cnt_n = cnt - CNT_1;
        end
      end
      BMARK: begin
        if (cnt == '0) begin
          state_n = BSPACE;
          cnt_n   = sreg[0] ? OS_L : ZS_L;
        end else begin
          cnt_n = cnt - CNT_1;
        end
      end
      BSPACE: begin
        if (cnt == '0) begin
          cnt_n = BM_L;
          if (bit_idx == 3'd7) begin
            if (last_byte) begin
              state_n = TMARK;
            end else begin
              // next byte fetched on the last space cycle so the mark follows with no gap
              state_n = BMARK;
              sreg_n  = mem[nxt_addr];
              byte_n  = byte_idx + LEN_1;
              bit_n   = '0;
            end
          end else begin
            state_n = BMARK;
            sreg_n  = {1'b0, sreg[7:1]};
            bit_n   = bit_idx + 3'd1;
          end
        end else begin
          cnt_n = cnt - CNT_1;
        end
      end
      TMARK: begin
        if (cnt == '0) begin
          state_n = FIN;
        end else begin
          cnt_n = cnt - CNT_1;
        end
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // abort only applies while busy; FIN already reports busy=0
    if (bus.abort && (state != IDLE) && (state != FIN)) begin
      state_n = IDLE;
      cnt_n   = '0;
    end

    env_n  = (state_n == HMARK) || (state_n == BMARK) || (state_n == TMARK);
    busy_n = (state_n != IDLE) && (state_n != FIN);
    done_n = (state_n == FIN);
  end

endmodule

// File: tb/tb_irtx_sequencer.sv
module tb_irtx_sequencer;
  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int CW    = 16;
  localparam int HM    = 20;
  localparam int HS    = 10;
  localparam int BM    = 4;
  localparam int OS    = 12;
  localparam int ZS    = 4;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   passed = 0;

  logic [7:0] mdl_mem [DEPTH];
  bit         exp_env [$];
  int         exp_len;

  irtx_sequencer_if #(.AW(AW)) bus ();

  irtx_sequencer #(
    .DEPTH(DEPTH), .AW(AW), .CW(CW),
    .HDR_MARK(HM), .HDR_SPACE(HS), .BIT_MARK(BM),
    .ONE_SPACE(OS), .ZERO_SPACE(ZS)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference: envelope as a flat list of per-cycle levels, plus the closed-form length.
  function automatic void build_model(input int n);
    int nb = (n > DEPTH) ? DEPTH : n;
    int n1 = 0;
    exp_env.delete();
    repeat (HM) exp_env.push_back(1'b1);
    repeat (HS) exp_env.push_back(1'b0);
    for (int b = 0; b < nb; b++) begin
      n1 += $countones(mdl_mem[b]);
      for (int i = 0; i < 8; i++) begin
        repeat (BM) exp_env.push_back(1'b1);
        if (mdl_mem[b][i]) repeat (OS) exp_env.push_back(1'b0);
        else               repeat (ZS) exp_env.push_back(1'b0);
      end
    end
    repeat (BM) exp_env.push_back(1'b1);
    exp_len = HM + HS + 8 * nb * BM + n1 * OS + (8 * nb - n1) * ZS + BM;
  endfunction

  task automatic write_byte(input int a, input logic [7:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = AW'(a);
    bus.wr_data = d;
    @(negedge clk);
    bus.wr_en   = 1'b0;
    mdl_mem[a]  = d;
  endtask

  task automatic pulse_go(input int n);
    bus.len = (AW+1)'(n);
    bus.go  = 1'b1;
    @(posedge clk);
    #1 bus.go = 1'b0;
  endtask

  // Follows a frame whose go was sampled at the previous posedge.
  // inj >= 0 drives a buffer write to addr 0 plus a go pulse at that frame cycle.
  task automatic check_frame(input string name, input int n, input int inj);
    int env_err = 0, busy_err = 0, first = -1, cyc = 0;
    bit seen = 1'b0;
    bit e;
    build_model(n);
    while (cyc < exp_len + 40) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      e = (cyc < exp_env.size()) ? exp_env[cyc] : 1'b0;
      if (bus.env !== e) begin
        env_err++;
        if (first < 0) first = cyc;
      end
      if (bus.busy !== 1'b1) busy_err++;
      if (inj >= 0 && cyc == inj) begin
        bus.wr_en   = 1'b1;
        bus.wr_addr = '0;
        bus.wr_data = ~mdl_mem[0];
        bus.go      = 1'b1;
      end else if (inj >= 0 && cyc == inj + 1) begin
        bus.wr_en = 1'b0;
        bus.go    = 1'b0;
      end
      cyc++;
    end
    checks++;
    if (env_err != 0)
      $display("FAIL %s env_stream: %0d wrong cycles (first at %0d), expected 0", name, env_err, first);
    else passed++;
    checks++;
    if (busy_err != 0)
      $display("FAIL %s busy_window: busy low on %0d frame cycles, expected 0", name, busy_err);
    else passed++;
    checks++;
    if (cyc != exp_len)
      $display("FAIL %s frame_len: got %0d cycles, expected %0d", name, cyc, exp_len);
    else passed++;
    checks++;
    if (!seen || bus.busy !== 1'b0 || bus.env !== 1'b0)
      $display("FAIL %s done_pulse: done=%0b busy=%0b env=%0b, expected done=1 busy=0 env=0",
               name, seen, bus.busy, bus.env);
    else passed++;
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL %s done_single: done=%0b busy=%0b, expected 0 0", name, bus.done, bus.busy);
    else passed++;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({bus.env, bus.busy, bus.done} !== 3'b000)
      $display("FAIL reset_hold: env/busy/done=%b, expected 000", {bus.env, bus.busy, bus.done});
    else passed++;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.env, bus.busy, bus.done} !== 3'b000)
      $display("FAIL reset_release: env/busy/done=%b, expected 000", {bus.env, bus.busy, bus.done});
    else passed++;
  endtask

  task automatic test_a5();
    write_byte(0, 8'hA5);
    pulse_go(1);
    check_frame("a5", 1, -1);
  endtask

  task automatic test_two_bytes();
    write_byte(0, 8'h00);
    write_byte(1, 8'hFF);
    pulse_go(2);
    check_frame("two_bytes", 2, -1);
  endtask

  task automatic test_len0();
    int err = 0;
    pulse_go(0);
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.env} !== 3'b100)
      $display("FAIL len0_busy: busy/done/env=%b, expected 100", {bus.busy, bus.done, bus.env});
    else passed++;
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.env} !== 3'b010)
      $display("FAIL len0_done: busy/done/env=%b, expected 010", {bus.busy, bus.done, bus.env});
    else passed++;
    repeat (5) begin
      @(negedge clk);
      if ({bus.busy, bus.done, bus.env} !== 3'b000) err++;
    end
    checks++;
    if (err != 0) $display("FAIL len0_quiet: %0d active cycles after done, expected 0", err);
    else passed++;
  endtask

  task automatic test_random();
    int n;
    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(1, 4);
      for (int a = 0; a < n; a++) write_byte(a, 8'($urandom));
      pulse_go(n);
      check_frame($sformatf("random%0d", it), n, -1);
    end
  endtask

  task automatic test_clamp();
    for (int a = 0; a < DEPTH; a++) write_byte(a, 8'($urandom));
    pulse_go(40);
    check_frame("clamp", 40, -1);
  endtask

  task automatic test_midframe();
    int err = 0;
    write_byte(0, 8'($urandom));
    write_byte(1, 8'($urandom));
    pulse_go(2);
    check_frame("midframe", 2, HM + HS + BM);
    repeat (40) begin
      @(negedge clk);
      if (bus.busy !== 1'b0 || bus.env !== 1'b0) err++;
    end
    checks++;
    if (err != 0) $display("FAIL midframe_no_retrigger: %0d active cycles, expected 0", err);
    else passed++;
    pulse_go(2);
    check_frame("midframe_intact", 2, -1);
  endtask

  task automatic test_abort();
    int ab, err = 0;
    write_byte(0, 8'($urandom));
    write_byte(1, 8'($urandom));
    build_model(2);
    ab = HM + HS + BM + (mdl_mem[0][0] ? OS : ZS) + BM + (mdl_mem[0][1] ? OS : ZS) + 1;
    pulse_go(2);
    for (int i = 0; i <= ab; i++) begin
      @(negedge clk);
      if (bus.env !== exp_env[i]) err++;
    end
    checks++;
    if (err != 0) $display("FAIL abort_prefix: %0d wrong env cycles, expected 0", err);
    else passed++;
    bus.abort = 1'b1;
    @(posedge clk);
    #1 bus.abort = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.env, bus.busy, bus.done} !== 3'b000)
      $display("FAIL abort_stop: env/busy/done=%b, expected 000", {bus.env, bus.busy, bus.done});
    else passed++;
    err = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) err++;
    end
    checks++;
    if (err != 0) $display("FAIL abort_no_done: %0d active cycles, expected 0", err);
    else passed++;
    bus.len   = (AW+1)'(2);
    bus.go    = 1'b1;
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.go    = 1'b0;
    bus.abort = 1'b0;
    err = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.busy !== 1'b0 || bus.env !== 1'b0) err++;
    end
    checks++;
    if (err != 0) $display("FAIL abort_beats_go: %0d active cycles, expected 0", err);
    else passed++;
    pulse_go(2);
    check_frame("after_abort", 2, -1);
  endtask

  task automatic test_go_held();
    write_byte(0, 8'($urandom));
    bus.len = (AW+1)'(1);
    bus.go  = 1'b1;
    @(posedge clk);
    check_frame("go_held", 1, -1);
    @(negedge clk);
    checks++;
    if ({bus.env, bus.busy} !== 2'b11)
      $display("FAIL go_held_restart: env/busy=%b, expected 11", {bus.env, bus.busy});
    else passed++;
    bus.go    = 1'b0;
    bus.abort = 1'b1;
    @(posedge clk);
    #1 bus.abort = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.env, bus.busy, bus.done} !== 3'b000)
      $display("FAIL go_held_abort: env/busy/done=%b, expected 000", {bus.env, bus.busy, bus.done});
    else passed++;
  endtask

  task automatic test_reset_mid();
    int err = 0;
    write_byte(0, 8'($urandom));
    build_model(1);
    pulse_go(1);
    for (int i = 0; i < HM + 5; i++) begin
      @(negedge clk);
      if (bus.env !== exp_env[i]) err++;
    end
    checks++;
    if (err != 0) $display("FAIL reset_mid_prefix: %0d wrong env cycles, expected 0", err);
    else passed++;
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({bus.env, bus.busy, bus.done} !== 3'b000)
      $display("FAIL reset_mid_async: env/busy/done=%b, expected 000", {bus.env, bus.busy, bus.done});
    else passed++;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.env, bus.busy, bus.done} !== 3'b000)
      $display("FAIL reset_mid_idle: env/busy/done=%b, expected 000", {bus.env, bus.busy, bus.done});
    else passed++;
    pulse_go(1);
    check_frame("after_reset", 1, -1);
  endtask

  initial begin
    reset       = 1'b1;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.len     = '0;
    bus.go      = 1'b0;
    bus.abort   = 1'b0;
    test_reset();
    test_a5();
    test_two_bytes();
    test_len0();
    test_random();
    test_clamp();
    test_midframe();
    test_abort();
    test_go_held();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
